// File: rtl/my_dmux8way16_reg.sv
// Registered 1-to-8 demultiplexer with a one-entry buffer and valid/ready handshake per lane.
// Define MY_DMUX_ROUNDROBIN_EN to steer words with a rotating pointer instead of sel.
module my_dmux8way16_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [WIDTH-1:0] out_e,
    output logic [WIDTH-1:0] out_f,
    output logic [WIDTH-1:0] out_g,
    output logic [WIDTH-1:0] out_h,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready
);
    // Handshake: a word moves when valid && ready are both high on a rising edge.
    logic [WIDTH-1:0] data_q [8];
    logic [WIDTH-1:0] data_d [8];
    logic [7:0]       valid_q;
    logic [7:0]       valid_d;
    logic [2:0]       lane;
    logic             take;

`ifdef MY_DMUX_ROUNDROBIN_EN
    logic [2:0] ptr_q;
    logic [2:0] ptr_d;
    logic       unused_sel;

    assign unused_sel = ^sel;
    assign lane       = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (take) begin
            ptr_d = ptr_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign lane = sel;
`endif

    // A lane draining on this edge can be reloaded on the same edge.
    assign in_ready = !valid_q[lane] || out_ready[lane];
    assign take     = in_valid && in_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~out_ready;
        if (take) begin
            data_d[lane]  = in;
            valid_d[lane] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= 8'h00;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_a     = data_q[0];
    assign out_b     = data_q[1];
    assign out_c     = data_q[2];
    assign out_d     = data_q[3];
    assign out_e     = data_q[4];
    assign out_f     = data_q[5];
    assign out_g     = data_q[6];
    assign out_h     = data_q[7];
    assign out_valid = valid_q;

endmodule

// File: tb/tb_my_dmux8way16_reg.sv
// Self-checking bench for my_dmux8way16_reg: directed steps plus random traffic
// against a lane-level reference model; honours MY_DMUX_ROUNDROBIN_EN.
module tb_my_dmux8way16_reg;
    logic        clk;
    logic        rst_n;
    logic [15:0] in_w;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic [15:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [15:0] outs [8];

    int checks = 0;
    int errors = 0;

    // reference model: what each lane holds and whether a consumer is owed a word
    logic [15:0] m_data [8];
    bit          m_full [8];
    int          m_ptr;

    my_dmux8way16_reg #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in(in_w), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .out_e(out_e), .out_f(out_f), .out_g(out_g), .out_h(out_h),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    assign outs[0] = out_a;
    assign outs[1] = out_b;
    assign outs[2] = out_c;
    assign outs[3] = out_d;
    assign outs[4] = out_e;
    assign outs[5] = out_f;
    assign outs[6] = out_g;
    assign outs[7] = out_h;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int target_lane();
`ifdef MY_DMUX_ROUNDROBIN_EN
        return m_ptr;
`else
        return int'(sel);
`endif
    endfunction

    function automatic logic exp_ready();
        int l = target_lane();
        return !m_full[l] || out_ready[l];
    endfunction

    function automatic logic [7:0] exp_valid();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_full[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_data[i] = 16'h0000;
            m_full[i] = 1'b0;
        end
        m_ptr = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":out_valid"}, 32'(out_valid), 32'(exp_valid()));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s:out_%c", tag, 8'h61 + i), 32'(outs[i]), 32'(m_data[i]));
        end
    endtask

    // Called in the low phase with inputs driven; returns at the next falling edge.
    task automatic step(input string tag);
        int  l;
        bit  acc;
        #1;
        chk({tag, ":in_ready"}, 32'(in_ready), 32'(exp_ready()));
        @(posedge clk);
        l   = target_lane();
        acc = in_valid && exp_ready();
        for (int i = 0; i < 8; i++) begin
            if (m_full[i] && out_ready[i]) m_full[i] = 1'b0;
        end
        if (acc) begin
            m_data[l] = in_w;
            m_full[l] = 1'b1;
            m_ptr     = (m_ptr + 1) % 8;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        logic [15:0] sweep [8];
        sweep = '{16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00, 16'h3333, 16'hCCCC, 16'h0F0F, 16'hF0F0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_w      = 16'h0000;
        sel       = 3'd0;
        out_ready = 8'h00;
        model_reset();

        // reset state, while held and just after release
        @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        chk("reset:in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        #1;
        chk("post_reset:in_ready", 32'(in_ready), 32'd1);

        // sweep all eight lanes with no consumer draining
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            sel      = 3'(i);
            in_w     = sweep[i];
            step($sformatf("sweep%0d", i));
        end
        chk("sweep:all_full", 32'(out_valid), 32'hFF);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1;
            chk($sformatf("sweep:stalled_sel%0d", i), 32'(in_ready), 32'd0);
        end

        // backpressure on lane c, then simultaneous drain and reload
        in_valid = 1'b1;
        sel      = 3'd2;
        in_w     = 16'h1234;
        for (int k = 0; k < 5; k++) begin
            step("bp_hold");
`ifndef MY_DMUX_ROUNDROBIN_EN
            chk("bp_hold:out_c", 32'(out_c), 32'h00FF);
`endif
        end
        out_ready = 8'h04;
        step("bp_release");
`ifndef MY_DMUX_ROUNDROBIN_EN
        chk("bp_release:out_c", 32'(out_c), 32'h1234);
        chk("bp_release:valid_c", 32'(out_valid[2]), 32'd1);
`endif

        // lane a stalled while lane h (emptied first) takes a word
        in_valid  = 1'b0;
        out_ready = 8'h80;
        step("indep_empty_h");
        out_ready = 8'h00;
        in_valid  = 1'b1;
        sel       = 3'd7;
        in_w      = 16'hBEEF;
        step("indep_send");
`ifndef MY_DMUX_ROUNDROBIN_EN
        chk("indep:out_h", 32'(out_h), 32'hBEEF);
        chk("indep:out_a", 32'(out_a), 32'h5555);
`endif

        // drain only lanes a and h
        in_valid  = 1'b0;
        out_ready = 8'h81;
        step("drain_only");
`ifndef MY_DMUX_ROUNDROBIN_EN
        chk("drain_only:out_valid", 32'(out_valid), 32'h7E);
`endif

        // random traffic
        for (int k = 0; k < 300; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            sel       = 3'($urandom_range(0, 7));
            in_w      = 16'($urandom);
            out_ready = 8'($urandom & $urandom);
            step("random");
        end

        // fill every lane, then reset in the middle of the high phase
        out_ready = 8'h00;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            sel      = 3'(i);
            in_w     = 16'($urandom) | 16'h0001;
            step("refill");
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        chk("async_reset:in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MY_DMUX_ROUNDROBIN_EN
        // ten words with sel pinned at 0: lanes a..h then a, b
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        sel       = 3'd0;
        for (int k = 0; k < 10; k++) begin
            in_w = 16'hA000 + 16'(k);
            step("rr_order");
            chk("rr_order:lane_word", 32'(outs[k % 8]), 32'(16'hA000 + 16'(k)));
        end
        // lane c stops draining: c fills, then the pointer wraps back to it and stalls
        out_ready = 8'hFB;
        for (int k = 0; k < 8; k++) begin
            in_w = 16'hB000 + 16'(k);
            step("rr_pass");
        end
        #1;
        chk("rr_stall:in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout checks=%0d required=completion", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/my_dmux8way16_reg.md
# my_dmux8way16_reg

Registered 1-to-8 demultiplexer for 16-bit words: routes each accepted input word to one of eight output lanes (a..h) selected by `sel`, holding it in a per-lane one-entry buffer until that lane's consumer takes it. It is the distributing counterpart of the 8-way 16-bit selector and sits between a single word producer and eight independent consumers in the chip-set datapath. Each lane has its own valid/ready handshake, so a stalled lane never blocks traffic to other lanes.

## Interface
- `WIDTH`, 16, data width of input and every lane
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `in`  input  WIDTH  input data word
- `in_valid`  input  1  producer offers `in`
- `in_ready`  output  1  block accepts `in` this cycle
- `sel`  input  3  destination lane: 000=a, 001=b, …, 111=h
- `out_a` … `out_h`  output  WIDTH each  lane data registers
- `out_valid`  output  8  bit i = lane i buffer full (bit 0 = a, bit 7 = h)
- `out_ready`  input  8  bit i = lane i consumer takes data this cycle

## Operation
- Transfer in: `in_valid && in_ready` on a rising edge.
- Transfer out on lane i: `out_valid[i] && out_ready[i]` on a rising edge.
- Target lane L = `sel`; or the round-robin pointer when `MY_DMUX_ROUNDROBIN_EN` is defined.
- `in_ready = !out_valid[L] || out_ready[L]`. This is combinational from `sel`/pointer, `out_valid` and `out_ready`, with no dependence on `in_valid`.
- On a transfer in:
  - `out_<L>` loads `in`.
  - `out_valid[L]` is 1 after the edge.
- Lanes other than L are unaffected by the input side. Their data registers hold their value.
- On a transfer out of lane i with no simultaneous load into i: `out_valid[i]` clears. `out_<i>` keeps its last value.
- Same lane drained and loaded in the same edge: `out_valid` stays 1 and the data is replaced by the new word. No bubble and no loss.
- Different lanes may drain in the same cycle, any subset of the eight.
- `in` and `sel` are ignored when `in_valid` = 0.
- A full lane with `out_ready` = 0 holds its data and valid indefinitely.
- Data is never dropped, duplicated or reordered within a lane.

## Timing
- Reset (asynchronous, `rst_n` = 0):
  - all `out_a`..`out_h` = 0
  - `out_valid` = 8'h00
  - round-robin pointer = 0
- With all lanes empty, `in_ready` = 1 during reset and immediately after reset.
- Reset asserted mid-operation discards every buffered word at once. No transfer completes on the edge coincident with `rst_n` = 0.
- Latency: a word accepted at edge n appears on `out_<L>` with `out_valid[L]` = 1 after edge n, i.e. in cycle n+1.
- Throughput: one word per cycle to a lane drained every cycle. A lane whose consumer never drains takes exactly one word.
- `out_*` and `out_valid` are purely registered. Only `in_ready` is combinational.

## Configuration
- `MY_DMUX_ROUNDROBIN_EN` defined:
  - `sel` is ignored.
  - A 3-bit pointer selects L and increments by 1 on each transfer in, wrapping from 7 to 0.
  - If the pointer's lane is full and not draining, input stalls even when other lanes are empty (strict order).
- Not defined: the pointer logic is absent and L = `sel` every cycle.

## Test plan
- Reset then sweep: sel 000..111 with `in` = 16'h5555, AAAA, 00FF, FF00, 3333, CCCC, 0F0F, F0F0, and `out_ready` = 0.
  - Each lane holds its word.
  - `out_valid` = 8'hFF after the 8th edge.
  - `in_ready` = 0 for any sel afterwards.
- Backpressure: lane c full with `out_ready` = 0, `in_valid` = 1, sel = 010, `in` = 16'h1234.
  - `in_ready` = 0.
  - `out_c` stays 16'h00FF for 5 cycles.
  - Raise `out_ready[2]`: same edge drains 00FF and loads 1234, and `out_valid[2]` stays 1.
- Independence: lane a full and stalled, send 16'hBEEF to sel = 111.
  - Accepted.
  - `out_h` = BEEF next cycle.
  - `out_a` unchanged.
- Drain only: `out_valid` = 8'hFF, `out_ready` = 8'h81, `in_valid` = 0.
  - After one edge `out_valid` = 8'h7E.
  - Data registers unchanged.
- Async reset: assert `rst_n` = 0 mid-cycle with lanes full.
  - `out_valid` = 0 and all `out_*` = 0 immediately, before the next clock edge.
- Round-robin (macro defined): 10 words with sel held at 000 and all `out_ready` = 1.
  - Words land on a,b,…,h,a,b in order.
  - Then stall lane c full: input stalls at the 3rd word of the next pass.
